// File: rtl/regfile_mp.sv
// Multi-port register file with a sequential zero-init sweep, a per-register busy scoreboard
// and optional same-cycle write-to-read forwarding. x0 reads as zero and is never stored.
module regfile_mp #(
  parameter int unsigned NumRegs       = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned AddressWidth  = 5,
  parameter int unsigned NumReadPorts  = 2,
  parameter int unsigned NumWritePorts = 2,
  parameter int unsigned Bypass        = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  output logic                                   ready_o,
  input  logic [NumWritePorts-1:0]               wr_en_i,
  input  logic [NumWritePorts*AddressWidth-1:0]  rd_addr_i,
  input  logic [NumWritePorts*DataWidth-1:0]     rd_data_i,
  input  logic [NumReadPorts*AddressWidth-1:0]   rs_addr_i,
  output logic [NumReadPorts*DataWidth-1:0]      rs_data_o,
  output logic [NumReadPorts-1:0]                rs_busy_o,
  input  logic                                   set_busy_en_i,
  input  logic [AddressWidth-1:0]                set_busy_addr_i
);

  typedef enum logic {
    StInit,
    StReady
  } state_e;

  state_e                  state_q, state_d;
  logic [AddressWidth-1:0] init_ptr_q, init_ptr_d;
  logic [NumRegs-1:0]      busy_q, busy_d;
  logic [DataWidth-1:0]    mem_q [NumRegs];
  logic [DataWidth-1:0]    mem_d [NumRegs];

  // Non-zero and inside the implemented register range.
  function automatic logic valid_addr(input logic [AddressWidth-1:0] a);
    return (a != '0) && (32'(a) < NumRegs);
  endfunction

  function automatic logic [AddressWidth-1:0] wr_addr(input int unsigned j);
    return rd_addr_i[j*AddressWidth +: AddressWidth];
  endfunction

  function automatic logic [DataWidth-1:0] wr_data(input int unsigned j);
    return rd_data_i[j*DataWidth +: DataWidth];
  endfunction

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    if (state_q == StInit) begin
      if (init_ptr_q == AddressWidth'(NumRegs - 1)) begin
        state_d = StReady;
      end else begin
        init_ptr_d = init_ptr_q + 1'b1;
      end
    end
  end

  // Ascending port order makes the highest-index write win; set_busy is applied last so it wins.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (state_q == StInit) begin
      mem_d[init_ptr_q] = '0;
    end else begin
      for (int unsigned j = 0; j < NumWritePorts; j++) begin
        if (wr_en_i[j] && valid_addr(wr_addr(j))) begin
          mem_d[wr_addr(j)]  = wr_data(j);
          busy_d[wr_addr(j)] = 1'b0;
        end
      end
      if (set_busy_en_i && valid_addr(set_busy_addr_i)) begin
        busy_d[set_busy_addr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StInit;
      init_ptr_q <= AddressWidth'(1);
      busy_q     <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      busy_q     <= busy_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign ready_o = (state_q == StReady);

  always_comb begin
    logic [AddressWidth-1:0] ra;
    logic [DataWidth-1:0]    rdata;
    logic                    rbusy;
    rs_data_o = '0;
    rs_busy_o = '0;
    for (int unsigned k = 0; k < NumReadPorts; k++) begin
      ra    = rs_addr_i[k*AddressWidth +: AddressWidth];
      rdata = '0;
      rbusy = 1'b0;
      if ((state_q == StReady) && valid_addr(ra)) begin
        rdata = mem_q[ra];
        rbusy = busy_q[ra];
        if (Bypass != 0) begin
          for (int unsigned j = 0; j < NumWritePorts; j++) begin
            if (wr_en_i[j] && (wr_addr(j) == ra)) begin
              rdata = wr_data(j);
              rbusy = 1'b0;
            end
          end
        end
      end
      rs_data_o[k*DataWidth +: DataWidth] = rdata;
      rs_busy_o[k]                        = rbusy;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a forwarding and a non-forwarding instance share stimulus and are
// compared against an array-based model plus a hand-computed vector table.
module tb_regfile_mp;

  localparam int NR  = 32;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRP = 2;
  localparam int NWP = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ready, ready_nb;
  logic [NWP-1:0]    wr_en;
  logic [NWP*AW-1:0] rd_addr;
  logic [NWP*DW-1:0] rd_data;
  logic [NRP*AW-1:0] rs_addr;
  logic [NRP*DW-1:0] rs_data, rs_data_nb;
  logic [NRP-1:0]    rs_busy, rs_busy_nb;
  logic              sb_en;
  logic [AW-1:0]     sb_addr;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp #(.NumRegs(NR), .DataWidth(DW), .AddressWidth(AW), .NumReadPorts(NRP),
               .NumWritePorts(NWP), .Bypass(1)) dut (
    .clk_i(clk), .rst_i(rst), .ready_o(ready), .wr_en_i(wr_en), .rd_addr_i(rd_addr),
    .rd_data_i(rd_data), .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
    .set_busy_en_i(sb_en), .set_busy_addr_i(sb_addr));

  regfile_mp #(.NumRegs(NR), .DataWidth(DW), .AddressWidth(AW), .NumReadPorts(NRP),
               .NumWritePorts(NWP), .Bypass(0)) dut_nb (
    .clk_i(clk), .rst_i(rst), .ready_o(ready_nb), .wr_en_i(wr_en), .rd_addr_i(rd_addr),
    .rd_data_i(rd_data), .rs_addr_i(rs_addr), .rs_data_o(rs_data_nb), .rs_busy_o(rs_busy_nb),
    .set_busy_en_i(sb_en), .set_busy_addr_i(sb_addr));

  always #5 clk = ~clk;

  // Reference model: register contents, busy bits and edges seen since reset release.
  logic [DW-1:0] m_regs [NR];
  bit            m_busy [NR];
  int            m_edges;

  function automatic bit m_ready();
    return m_edges >= NR - 1;
  endfunction

  function automatic logic [AW-1:0] wa(int j);
    return rd_addr[j*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] wd(int j);
    return rd_data[j*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_data(logic [AW-1:0] a, bit byp);
    logic [DW-1:0] v;
    if (!m_ready() || a == 0) return '0;
    v = m_regs[a];
    if (byp)
      for (int j = 0; j < NWP; j++)
        if (wr_en[j] && wa(j) == a) v = wd(j);
    return v;
  endfunction

  function automatic bit exp_busy(logic [AW-1:0] a, bit byp);
    if (!m_ready() || a == 0) return 1'b0;
    if (byp)
      for (int j = 0; j < NWP; j++)
        if (wr_en[j] && wa(j) == a) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    for (int i = 0; i < NR; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_model();
    logic [AW-1:0] a;
    check("ready", 32'(ready), 32'(m_ready()));
    check("ready_nb", 32'(ready_nb), 32'(m_ready()));
    for (int k = 0; k < NRP; k++) begin
      a = rs_addr[k*AW +: AW];
      check($sformatf("data_bp[%0d] x%0d", k, a), rs_data[k*DW +: DW], exp_data(a, 1'b1));
      check($sformatf("busy_bp[%0d] x%0d", k, a), 32'(rs_busy[k]), 32'(exp_busy(a, 1'b1)));
      check($sformatf("data_nb[%0d] x%0d", k, a), rs_data_nb[k*DW +: DW], exp_data(a, 1'b0));
      check($sformatf("busy_nb[%0d] x%0d", k, a), 32'(rs_busy_nb[k]), 32'(exp_busy(a, 1'b0)));
    end
  endtask

  task automatic update_model();
    if (!m_ready()) begin
      m_edges++;
    end else begin
      for (int j = 0; j < NWP; j++)
        if (wr_en[j] && wa(j) != 0) begin
          m_regs[wa(j)] = wd(j);
          m_busy[wa(j)] = 1'b0;
        end
      if (sb_en && sb_addr != 0) m_busy[sb_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
    return AW'($urandom_range(0, NR - 1));
  endfunction

  task automatic rand_inputs();
    wr_en = NWP'($urandom_range(0, 3));
    for (int j = 0; j < NWP; j++) begin
      rd_addr[j*AW +: AW] = rand_addr();
      rd_data[j*DW +: DW] = $urandom;
    end
    for (int k = 0; k < NRP; k++) rs_addr[k*AW +: AW] = rand_addr();
    sb_en   = ($urandom_range(0, 2) == 0);
    sb_addr = rand_addr();
  endtask

  typedef struct {
    logic [1:0]    we;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    logic [AW-1:0] ra0, ra1;
    logic          sb;
    logic [AW-1:0] sba;
    logic [DW-1:0] d0, d1, nd0;
    logic          b0, b1, nb0;
  } vec_t;

  vec_t vt [13];

  initial begin
    int edges;

    // we, wa0, wa1, wd0, wd1, ra0, ra1, sb, sba, d0(bp), d1(bp), d0(nb), b0(bp), b1(bp), b0(nb)
    vt[0]  = '{2'b11, 5'd5, 5'd5, 32'hDEADBEEF, 32'h12345678, 5'd5, 5'd0, 1'b0, 5'd0,
               32'h12345678, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0,
               32'h12345678, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd5, 1'b0, 5'd0,
               32'h0, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{2'b01, 5'd7, 5'd0, 32'hA5A5A5A5, 32'h0, 5'd7, 5'd5, 1'b0, 5'd0,
               32'hA5A5A5A5, 32'h12345678, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0,
               32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3,
               32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd0, 1'b0, 5'd0,
               32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1};
    vt[7]  = '{2'b10, 5'd0, 5'd3, 32'h0, 32'h11112222, 5'd3, 5'd3, 1'b0, 5'd0,
               32'h11112222, 32'h11112222, 32'h0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0,
               32'h11112222, 32'h11112222, 32'h11112222, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{2'b01, 5'd3, 5'd0, 32'h33334444, 32'h0, 5'd3, 5'd3, 1'b1, 5'd3,
               32'h33334444, 32'h33334444, 32'h11112222, 1'b0, 1'b0, 1'b0};
    vt[10] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0,
               32'h33334444, 32'h33334444, 32'h33334444, 1'b1, 1'b1, 1'b1};
    vt[11] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3, 1'b1, 5'd0,
               32'h0, 32'h33334444, 32'h0, 1'b0, 1'b1, 1'b0};
    vt[12] = '{2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3, 1'b0, 5'd0,
               32'h0, 32'h33334444, 32'h0, 1'b0, 1'b1, 1'b0};

    wr_en = '0; rd_addr = '0; rd_data = '0; rs_addr = '0; sb_en = 1'b0; sb_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_model();

    // Partial init, then reset in the middle of it, with writes/set_busy hammering throughout.
    rst = 1'b0;
    for (int e = 0; e < 10; e++) begin
      rand_inputs();
      tick();
    end
    rst = 1'b1;
    model_reset();
    #1;
    check("reinit_ready", 32'(ready), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    edges = 0;
    while (ready !== 1'b1 && edges < 200) begin
      rand_inputs();
      tick();
      edges++;
    end
    check("init_edges", 32'(edges), 32'(NR - 1));

    // Every register zero and idle after init despite the ignored traffic.
    wr_en = '0; sb_en = 1'b0;
    for (int a = 0; a < NR; a++) begin
      rs_addr = {AW'(NR - 1 - a), AW'(a)};
      tick();
    end

    for (int i = 0; i < 13; i++) begin
      wr_en   = vt[i].we;
      rd_addr = {vt[i].wa1, vt[i].wa0};
      rd_data = {vt[i].wd1, vt[i].wd0};
      rs_addr = {vt[i].ra1, vt[i].ra0};
      sb_en   = vt[i].sb;
      sb_addr = vt[i].sba;
      @(negedge clk);
      check($sformatf("vec%0d d0", i), rs_data[DW-1:0], vt[i].d0);
      check($sformatf("vec%0d d1", i), rs_data[2*DW-1:DW], vt[i].d1);
      check($sformatf("vec%0d nb_d0", i), rs_data_nb[DW-1:0], vt[i].nd0);
      check($sformatf("vec%0d b0", i), 32'(rs_busy[0]), 32'(vt[i].b0));
      check($sformatf("vec%0d b1", i), 32'(rs_busy[1]), 32'(vt[i].b1));
      check($sformatf("vec%0d nb_b0", i), 32'(rs_busy_nb[0]), 32'(vt[i].nb0));
      @(posedge clk);
      update_model();
      #1;
    end

    for (int c = 0; c < 10000; c++) begin
      rand_inputs();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
